// File: rtl/clk_div_pkg.sv
// Shared clock-rate constants for the slow-enable dividers running off the
// 100 MHz system clock.
package clk_div_pkg;

  localparam int unsigned CLK_HZ     = 100_000_000;
  localparam int unsigned HALF_10HZ  = 4_999_999;
  localparam int unsigned HALF_500HZ = 99_999;

  // Half-period reload value giving a square wave of freq_hz.
  function automatic int unsigned half_for(input int unsigned freq_hz);
    return CLK_HZ / (2 * freq_hz) - 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Valid/ready reload port shared by all divider channels.
interface clk_div_multi_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 23
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_valid;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic              cfg_ready;

  modport master (output cfg_valid, cfg_ch, cfg_half, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_half, output cfg_ready);
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, 50% square wave, rise strobe and
// a one-deep pending reload that lands on the next wrap.
module clk_div_chan #(
  parameter int               CNT_W     = 23,
  parameter logic [CNT_W-1:0] HALF_INIT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d      = cnt_q;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;

    if (!en) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        half_d = pend_val_q;
        pend_d = 1'b0;
      end
      // load is only granted while pend is clear, so the two never collide
      if (load) begin
        half_d = load_val;
      end
    end else begin
      if (cnt_q == half_q) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
        if (pend_q) begin
          half_d = pend_val_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // a load on the wrap edge itself is held over to the following wrap
      if (load) begin
        pend_d     = 1'b1;
        pend_val_d = load_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      half_q     <= HALF_INIT;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  assign busy    = pend_q;
  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable generator: config decode and ready mux in front
// of NUM_CH independent divider channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH   = 2,
  parameter int          CNT_W    = 23,
  parameter int unsigned DIV_INIT = HALF_10HZ
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  clk_div_multi_if.slave    cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] load;
  logic              ready_c;

  // Out-of-range channel numbers match nothing: always ready, never loaded.
  always_comb begin
    ready_c = 1'b1;
    load    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        ready_c = ~busy[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = cfg.cfg_valid & ready_c & (cfg.cfg_ch == CH_W'(i));
    end
  end

  assign cfg.cfg_ready = ready_c;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W     (CNT_W),
      .HALF_INIT (CNT_W'(DIV_INIT))
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[g]),
      .load     (load[g]),
      .load_val (cfg.cfg_half),
      .busy     (busy[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: expected tick cycles are queued per channel
// when stimulus is applied and consumed by a negedge monitor.
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en;
  logic [1:0] clk_out, tick;
  logic [2:0] en3, clk_out3, tick3;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int q0[$];
  int q1[$];
  logic [1:0] prev_clk = 2'b00;
  int e;

  clk_div_multi_if #(.NUM_CH(2), .CNT_W(8)) cfg_if ();
  clk_div_multi_if #(.NUM_CH(3), .CNT_W(8)) cfg_if3 ();

  clk_div_multi #(.NUM_CH(2), .CNT_W(8), .DIV_INIT(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg(cfg_if),
    .clk_out(clk_out), .tick(tick)
  );

  clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DIV_INIT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .cfg(cfg_if3),
    .clk_out(clk_out3), .tick(tick3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic push(input int c, input int first, input int per, input int n);
    for (int k = 0; k < n; k++) begin
      if (c == 0) q0.push_back(first + k * per);
      else        q1.push_back(first + k * per);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic end_phase(input string tag);
    en = 2'b00;
    step(2);
    check({tag, "_clk_low"}, 32'(clk_out), 0);
    check({tag, "_tick_low"}, 32'(tick), 0);
    check({tag, "_ticks_seen0"}, q0.size(), 0);
    check({tag, "_ticks_seen1"}, q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  // Scoreboard side: every observed tick must be queued and on time, on a rise.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int c = 0; c < 2; c++) begin
        if (tick[c]) begin
          int have;
          int exp_c;
          check($sformatf("tick%0d_on_rise", c), {30'd0, prev_clk[c], clk_out[c]}, 32'd1);
          have = (c == 0) ? q0.size() : q1.size();
          check($sformatf("tick%0d_expected", c), 32'(have > 0), 1);
          if (have > 0) begin
            if (c == 0) exp_c = q0.pop_front();
            else        exp_c = q1.pop_front();
            check($sformatf("tick%0d_time", c), cyc, exp_c);
          end
        end
      end
    end
    prev_clk = clk_out;
  end

  initial begin
    rst_n = 1'b1;
    en = 2'b00;
    en3 = 3'b000;
    cfg_if.cfg_valid = 1'b0;  cfg_if.cfg_ch = '0;  cfg_if.cfg_half = '0;
    cfg_if3.cfg_valid = 1'b0; cfg_if3.cfg_ch = '0; cfg_if3.cfg_half = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 1);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Both channels from reset, half = 3.
    e = cyc + 1;
    en = 2'b11;
    push(0, e + 3, 8, 3);
    push(1, e + 3, 8, 3);
    step(4);
    for (int k = 0; k < 8; k++) begin
      check("p1_duty", 32'(clk_out[0]), 32'(k < 4));
      step(1);
    end
    step(9);
    end_phase("p1");

    // Mid-period reload on running ch0.
    e = cyc + 1;
    en = 2'b01;
    push(0, e + 3, 8, 1);
    push(0, e + 9, 4, 3);
    cfg_if.cfg_ch = 1'b0;
    cfg_if.cfg_half = 8'd1;
    step(6);
    check("p2_ready_before", 32'(cfg_if.cfg_ready), 1);
    cfg_if.cfg_valid = 1'b1;
    step(1);
    cfg_if.cfg_valid = 1'b0;
    check("p2_ready_pending", 32'(cfg_if.cfg_ready), 0);
    step(1);
    check("p2_ready_applied", 32'(cfg_if.cfg_ready), 1);
    check("p2_old_half_fall", 32'(clk_out[0]), 0);
    step(2);
    check("p2_new_half_rise", 32'(clk_out[0]), 1);
    step(9);
    end_phase("p2");

    // Direct reload of disabled ch0 back to 3, then reload ch1 on its wrap edge.
    cfg_if.cfg_ch = 1'b0;
    cfg_if.cfg_half = 8'd3;
    cfg_if.cfg_valid = 1'b1;
    check("p3_ready_disabled", 32'(cfg_if.cfg_ready), 1);
    step(1);
    cfg_if.cfg_valid = 1'b0;
    check("p3_no_pend_disabled", 32'(cfg_if.cfg_ready), 1);
    e = cyc + 1;
    en = 2'b10;
    push(1, e + 3, 8, 2);
    push(1, e + 27, 16, 2);
    cfg_if.cfg_ch = 1'b1;
    cfg_if.cfg_half = 8'd7;
    step(7);
    cfg_if.cfg_valid = 1'b1;
    step(1);
    cfg_if.cfg_valid = 1'b0;
    check("p3_ready_pending", 32'(cfg_if.cfg_ready), 0);
    check("p3_wrap_old_fall", 32'(clk_out[1]), 0);
    step(4);
    check("p3_ready_applied", 32'(cfg_if.cfg_ready), 1);
    check("p3_old_half_rise", 32'(clk_out[1]), 1);
    step(7);
    check("p3_new_half_high", 32'(clk_out[1]), 1);
    step(1);
    check("p3_new_half_fall", 32'(clk_out[1]), 0);
    step(25);
    end_phase("p3");

    // en[0] dropped for five edges; ch1 (half 7) keeps running.
    e = cyc + 1;
    en = 2'b11;
    push(0, e + 3, 8, 2);
    push(0, e + 22, 8, 3);
    push(1, e + 7, 16, 3);
    step(14);
    en = 2'b10;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("p4_dis_clk", 32'(clk_out[0]), 0);
      check("p4_dis_tick", 32'(tick[0]), 0);
    end
    en = 2'b11;
    step(22);
    end_phase("p4");

    // Half = 0 on disabled ch1; out-of-range channel on the 3-channel instance.
    cfg_if.cfg_ch = 1'b1;
    cfg_if.cfg_half = 8'd0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if3.cfg_ch = 2'd3;
    cfg_if3.cfg_half = 8'd0;
    cfg_if3.cfg_valid = 1'b1;
    check("p5_ready_ch1", 32'(cfg_if.cfg_ready), 1);
    check("p5_ready_oor", 32'(cfg_if3.cfg_ready), 1);
    step(1);
    cfg_if.cfg_valid = 1'b0;
    cfg_if3.cfg_valid = 1'b0;
    e = cyc + 1;
    en = 2'b10;
    en3 = 3'b111;
    push(1, e, 2, 5);
    step(1);
    check("p5_h0_rise0", 32'(clk_out[1]), 1);
    check("p5_oor_no_early", 32'(tick3), 0);
    step(1);
    check("p5_h0_fall", 32'(clk_out[1]), 0);
    step(1);
    check("p5_h0_rise1", 32'(clk_out[1]), 1);
    step(1);
    check("p5_oor_unchanged", 32'(tick3), 32'h7);
    step(6);
    en3 = 3'b000;
    end_phase("p5");

    // Async reset while a reload is pending on ch0.
    e = cyc + 1;
    en = 2'b01;
    push(0, e + 3, 8, 1);
    cfg_if.cfg_ch = 1'b0;
    cfg_if.cfg_half = 8'd0;
    step(5);
    cfg_if.cfg_valid = 1'b1;
    step(1);
    cfg_if.cfg_valid = 1'b0;
    check("p6_ready_pending", 32'(cfg_if.cfg_ready), 0);
    check("p6_clk_high", 32'(clk_out[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("p6_rst_clk_out", 32'(clk_out), 0);
    check("p6_rst_tick", 32'(tick), 0);
    check("p6_rst_ready", 32'(cfg_if.cfg_ready), 1);
    check("p6_tick_before_rst", q0.size(), 0);
    step(1);
    rst_n = 1'b1;
    e = cyc + 1;
    push(0, e + 3, 8, 2);
    step(13);
    end_phase("p6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
